// File: rtl/freq_meter_sequencer_if.sv
// Control/status bundle between the frequency meter sequencer and its
// surroundings (measurement controller on one side, datapath on the other).
interface freq_meter_sequencer_if;
    logic       start;
    logic       auto_range;
    logic [1:0] range_sel;
    logic       overflow;
    logic       underrange;
    logic       cnt_clr;
    logic       cnt_en;
    logic       latch;
    logic [1:0] range;
    logic       busy;
    logic       meas_done;
    logic       ovf_flag;

    modport master (
        output start, auto_range, range_sel, overflow, underrange,
        input  cnt_clr, cnt_en, latch, range, busy, meas_done, ovf_flag
    );

    modport slave (
        input  start, auto_range, range_sel, overflow, underrange,
        output cnt_clr, cnt_en, latch, range, busy, meas_done, ovf_flag
    );
endinterface

// File: rtl/freq_meter_sequencer.sv
// Gate-time sequencer for the frequency meter: clear/gate/latch control
// with selectable 1 s / 100 ms / 10 ms gates and overflow autoranging.
module freq_meter_sequencer #(
    parameter int TICKS_PER_MS = 1000,
    parameter int HOLD_MS      = 200,
    parameter int TW           = 24
) (
    input  logic clk,
    input  logic reset,
    freq_meter_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_GATE, S_EVAL, S_HOLD
    } state_t;

    localparam logic [TW-1:0] G0 = TW'(1000 * TICKS_PER_MS - 1);
    localparam logic [TW-1:0] G1 = TW'(100 * TICKS_PER_MS - 1);
    localparam logic [TW-1:0] G2 = TW'(10 * TICKS_PER_MS - 1);
    localparam logic [TW-1:0] HT = TW'(HOLD_MS * TICKS_PER_MS - 1);

    state_t        r_state, w_next;
    logic [1:0]    r_wrange, w_wrange_nxt;
    logic          r_supp, w_supp_nxt;
    logic [TW-1:0] r_tick, w_tick_nxt;
    logic          w_accept;
    logic [1:0]    w_sel;

    logic          r_cnt_clr, r_cnt_en, r_latch, r_done;
    logic          r_busy, r_ovf;
    logic [1:0]    r_range;

    assign w_sel = (bus.range_sel == 2'd3) ? 2'd2 : bus.range_sel;

    always_comb begin
        w_next       = r_state;
        w_wrange_nxt = r_wrange;
        w_supp_nxt   = r_supp;
        w_tick_nxt   = r_tick;
        w_accept     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = S_CLEAR;
                    if (!bus.auto_range) w_wrange_nxt = w_sel;
                end
            end
            S_CLEAR: begin
                w_next = S_GATE;
                case (r_wrange)
                    2'd0:    w_tick_nxt = G0;
                    2'd1:    w_tick_nxt = G1;
                    default: w_tick_nxt = G2;
                endcase
            end
            S_GATE: begin
                if (r_tick == '0) w_next = S_EVAL;
                else w_tick_nxt = r_tick - 1'b1;
            end
            S_EVAL: begin
                // Suppress bit blocks the first down-range after an up-range
                if (bus.auto_range && bus.overflow && r_wrange < 2'd2) begin
                    w_wrange_nxt = r_wrange + 2'd1;
                    w_supp_nxt   = 1'b1;
                    w_next       = S_CLEAR;
                end else if (bus.auto_range && !bus.overflow &&
                             bus.underrange && r_wrange != 2'd0 &&
                             !r_supp) begin
                    w_wrange_nxt = r_wrange - 2'd1;
                    w_next       = S_CLEAR;
                end else begin
                    w_accept   = 1'b1;
                    w_supp_nxt = 1'b0;
                    w_tick_nxt = HT;
                    w_next     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (r_tick != '0) begin
                    w_tick_nxt = r_tick - 1'b1;
                end else if (bus.start) begin
                    w_next = S_CLEAR;
                    if (!bus.auto_range) w_wrange_nxt = w_sel;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_wrange  <= 2'd0;
            r_supp    <= 1'b0;
            r_tick    <= '0;
            r_cnt_clr <= 1'b0;
            r_cnt_en  <= 1'b0;
            r_latch   <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_ovf     <= 1'b0;
            r_range   <= 2'd0;
        end else begin
            r_state   <= w_next;
            r_wrange  <= w_wrange_nxt;
            r_supp    <= w_supp_nxt;
            r_tick    <= w_tick_nxt;
            r_cnt_clr <= (w_next == S_CLEAR);
            r_cnt_en  <= (w_next == S_GATE);
            r_latch   <= w_accept;
            r_done    <= w_accept;
            r_busy    <= (w_next != S_IDLE);
            if (w_accept) begin
                r_range <= r_wrange;
                r_ovf   <= bus.overflow;
            end
        end
    end

    assign bus.cnt_clr   = r_cnt_clr;
    assign bus.cnt_en    = r_cnt_en;
    assign bus.latch     = r_latch;
    assign bus.meas_done = r_done;
    assign bus.busy      = r_busy;
    assign bus.ovf_flag  = r_ovf;
    assign bus.range     = r_range;
endmodule

// File: doc/freq_meter_sequencer.md
Name: freq_meter_sequencer

Overview:
Clock-domain measurement sequencer for the frequency meter counting datapath. It generates the clear, count-gate and latch controls from the system clock instead of a 1 Hz strobe, so gate time is selectable (1 s / 100 ms / 10 ms). It autoranges on counter overflow and under-range. It sits between the system clock and the decade counter/latch/display chain, and drives the display decimal-point range.

Parameters:
TICKS_PER_MS, 1000, clk cycles per 1 ms of gate time (1 MHz clk default)
HOLD_MS, 200, display hold time after each accepted measurement, in ms
TW, 24, width of internal tick counter; must hold 1000*TICKS_PER_MS

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  level; 1 = measure continuously, 0 = finish current cycle then idle
auto_range  in  1  1 = autorange, 0 = manual range from range_sel
range_sel  in  2  manual range: 0=1000 ms, 1=100 ms, 2=10 ms gate; 3 treated as 2
overflow  in  1  datapath count overflowed during current gate (sticky until cnt_clr)
underrange  in  1  datapath count below down-range threshold
cnt_clr  out  1  one-cycle active-high synchronous clear to counters
cnt_en  out  1  counting gate
latch  out  1  one-cycle pulse: load count into display latch
range  out  2  range of the currently latched result
busy  out  1  high in every state except IDLE
meas_done  out  1  one-cycle pulse, coincident with latch
ovf_flag  out  1  overflow status of the latched result

Behaviour:
- All outputs registered (Moore). Reset: state=IDLE, cnt_clr=0, cnt_en=0, latch=0, meas_done=0, busy=0, ovf_flag=0, range=0, internal work range=0, up-range-suppress bit=0, tick counter=0.
- States: IDLE, CLEAR, GATE, EVAL, HOLD.
- IDLE: if start=1, go to CLEAR on the next edge.
- CLEAR: exactly 1 cycle. cnt_clr=1. Go to GATE.
- GATE: cnt_en=1 for exactly G cycles. G = 1000, 100 or 10 times TICKS_PER_MS for work range 0, 1, 2. Go to EVAL.
- EVAL: exactly 1 cycle. overflow and underrange are sampled here.
  - Auto, up-range: overflow=1 and work range<2. Increment work range, set suppress bit, no latch, go directly to CLEAR.
  - Auto, down-range: overflow=0, underrange=1, work range>0 and suppress=0. Decrement work range, no latch, go directly to CLEAR.
  - Otherwise accept the result: latch=1, meas_done=1, range<=work range, ovf_flag<=overflow, clear suppress bit, go to HOLD.
  - Manual mode always accepts.
  - Range 2 with overflow: accepted with ovf_flag=1.
- HOLD: HOLD_MS*TICKS_PER_MS cycles, all strobes low. Then go to CLEAR if start=1, else IDLE.
- Manual range: range_sel (3 clamped to 2) loads the work range on every transition into CLEAR from IDLE or HOLD. It is ignored mid-measurement.
- auto_range is sampled only in EVAL. Toggling it mid-gate does not disturb the current gate.
- start=0 mid-measurement: the current CLEAR/GATE/EVAL/HOLD completes normally, then the block goes to IDLE.
- The suppress bit prevents up/down oscillation: one down-range is blocked in the measurement immediately after an up-range.
- The tick counter reloads at every state entry, with no drift. Gate length is exact to the cycle in every range.
- Asynchronous reset mid-gate: cnt_en drops immediately and the range returns to 0.

Test Plan:
(TICKS_PER_MS=4, HOLD_MS=2 for all scenarios.)
- Manual range 2, start=1 held: cnt_clr 1 cycle, then cnt_en exactly 40 cycles, then latch+meas_done 1 cycle, then 8 idle cycles, then cnt_clr again. range=2, busy=1 throughout.
- Manual range 0, overflow=0: cnt_en exactly 4000 cycles. range_sel changed to 1 mid-gate is ignored; the next measurement's gate is 400 cycles.
- Auto, range 0, overflow=1 in first EVAL, 0 in second: no latch on the first EVAL, immediate cnt_clr, 400-cycle gate. Then latch with range=1, ovf_flag=0.
- Auto, overflow=1 at every EVAL: range steps 0→1→2 without latching, then latches at range 2 with ovf_flag=1.
- Auto, up-range then underrange=1: the first down-range is suppressed and the result latches at the higher range. The next underrange EVAL steps the range down.
- reset asserted at gate cycle 20: all outputs 0 asynchronously, range=0. After release with start=1, a full 4000-cycle gate follows. With start=0 mid-HOLD, the block enters IDLE and busy=0.
